// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver FSM states and the
// clock-divider helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Oversample-tick divisor, truncated; callers must keep the result >= 1.
  function automatic int unsigned uart_div(input int unsigned clk, input int unsigned baud);
    return clk / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side and line-side signals of the UART receiver. The receiver takes the
// master view; the consumer (and bench) takes the slave view.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ack;
  logic                 overrun;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rxd,
    input  data_ack,
    output data,
    output data_valid,
    output overrun,
    output frame_err,
    output busy
  );

  modport slave (
    output rxd,
    output data_ack,
    input  data,
    input  data_valid,
    input  overrun,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle tick every DIV clocks; shared by
// the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     CntW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntLast);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation, stop-bit
// check, and a held output byte with valid/ack handshake and overrun flag.
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_receiver_if.master bus
);
  import uart_pkg::*;

  localparam int unsigned     DIV     = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned     CntW    = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam int unsigned     BitW    = $clog2(DATA_BITS);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;
  logic                 stop_bad;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], bus.rxd};
    end
  end

  // Bit framing: count oversample ticks, sample mid-bit, LSB arrives first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    accept   = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_s != IDLE_LEVEL) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (cnt_q == CntMid) begin
            if (rx_s == IDLE_LEVEL) begin
              state_d = StIdle;
            end else begin
              cnt_d   = '0;
              bit_d   = '0;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BitW'(1);
            if (bit_q == BitLast) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (rx_s == IDLE_LEVEL) begin
              accept  = 1'b1;
              state_d = StIdle;
            end else begin
              stop_bad = 1'b1;
              state_d  = StBreak;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StBreak: begin
        if (rx_s == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // An accept always wins over a same-cycle ack; overrun needs an unacked byte.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = stop_bad;
    if (accept) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !bus.data_ack) begin
        overrun_d = 1'b1;
      end
    end else if (bus.data_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first: the receive end of the link driven by the team's `transmitter` block. It oversamples the asynchronous `rxd` line 16× per bit, validates the start bit and checks the stop bit. Each received byte is presented on a held output register with a valid/ack handshake, and overrun and framing errors are flagged. It sits inside the TinyTapeout top, with `rxd` taken from `ui_in` and the byte and status routed to `uo_out`/`uio_out`.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line bit rate.
- `OVERSAMPLE`, 16: samples per bit; fixed at 16 in this revision.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rxd` in 1: asynchronous serial input; idles high.
- `data` out 8: last accepted byte; held until overwritten.
- `data_valid` out 1: level; high while `data` holds an unacknowledged byte.
- `data_ack` in 1: consumer acknowledge; clears `data_valid`.
- `overrun` out 1: sticky; set when a byte completes while `data_valid` is high.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Input sync:** `rxd` passes through a 2-FF synchronizer, reset to 1. All logic uses the synchronized value `rx_s`.
- **Tick generator:** `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer-truncated, with `DIV >= 1` required.
  - The counter emits `tick` for one cycle every `DIV` clocks.
  - The counter free-runs and is not re-phased on start.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** `rx_s == 0` → START; the 4-bit tick count is cleared.
  - **START:** on the 8th tick (count 7, mid-bit), if `rx_s == 1` → IDLE (glitch rejected, no output); else clear count and bit index → DATA.
  - **DATA:** every 16th tick, sample `rx_s` into the shift register MSB and shift right. After bit index 7 → STOP.
  - **STOP:** on the 16th tick:
    - `rx_s == 1` → accept the byte, return to IDLE.
    - `rx_s == 0` → pulse `frame_err`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rx_s == 1`, then → IDLE.
- **Accept:**
  - The cycle after the stop sample, `data` ← shift register and `data_valid` ← 1.
  - If `data_valid` was already 1, `data` is still overwritten and `overrun` ← 1.
- **Handshake:**
  - `data_ack` high for a cycle while `data_valid` is high → `data_valid` ← 0 next cycle.
  - `data_ack` while `data_valid` is low is ignored.
  - Accept and `data_ack` in the same cycle: the accept wins; `data_valid` stays 1 and `overrun` is not set.
- **Overrun clear:** `overrun` clears only when `data_ack` is high and no accept happens in that cycle.
- **Reset values:** `data` = 0x00, `data_valid` = 0, `overrun` = 0, `frame_err` = 0, `busy` = 0. FSM in IDLE, shift register 0, synchronizer FFs 1.
- **Reset mid-frame:** everything returns immediately to reset values; the partial byte is lost. After release, a line that is still low is treated as a new start.

## Timing
- Start-edge detection latency: 2 clocks (synchronizer) plus 1 clock (FSM).
- Data bit n is sampled `(24 + 16n)` ticks after the start is detected; the stop bit at 152 ticks.
- `data_valid` rises 1 clock after the stop-bit sample tick.
- Jitter of up to ±1 tick from the free-running divider is acceptable.
- Tolerated baud mismatch is ≥ ±3%.
- `frame_err` is coincident with the cycle after the stop sample, the same cycle in which `data_valid` would have risen.
- `busy` rises 1 clock after the synchronized falling edge. It falls in the cycle `data_valid` rises, or on exit from BREAK.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - `OVERSAMPLE` constant.
  - Frame constants: `DATA_BITS = 8`, idle level 1.
  - A `uart_div(clk, baud)` function, reused by `transmitter`.
- One sub-module, `uart_baud_tick`, holding the divider and tick pulse. It is parameterized by divisor so the transmitter can share it.
- Synchronizer, FSM, shift register and output register live in `uart_receiver`.

## Test plan
All scenarios use `CLK_FREQ = 1_600_000`, `BAUD = 100_000`, so `DIV = 1` and one bit is 16 clocks.

- **Single byte:** send 0xA5 8N1 → `data` = 0xA5, `data_valid` high within 2 clocks after the stop midpoint; `overrun` = 0, `frame_err` never pulses.
- **Glitch reject:** drive `rxd` low for 5 clocks, then high → FSM returns to IDLE; `busy` falls; no `data_valid`.
- **Overrun:** send 0x3C then 0xC3 back-to-back with no ack → `data` = 0xC3, `data_valid` = 1, `overrun` = 1. A single `data_ack` clears both.
- **Framing / break:**
  - Send 0x55 with the stop bit forced low → one-cycle `frame_err`, `data`/`data_valid` unchanged.
  - Hold the line low for 40 clocks, then release, then send 0x81 → 0x81 received correctly.
- **Ack/accept collision:** assert `data_ack` in the exact cycle the second byte is accepted → `data_valid` stays 1 and `overrun` stays 0.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of 0xFF → all outputs at reset values. After release with the line idle, 0x0F is received correctly.
